// File: rtl/acog_hub_resp_pkg.sv
// Hub operation codes and responder state encoding shared by the hub responder and its lane helper.
package acog_hub_resp_pkg;

  localparam logic [4:0] HUB_RDBYTE = 5'h00;
  localparam logic [4:0] HUB_RDWORD = 5'h01;
  localparam logic [4:0] HUB_RDLONG = 5'h02;
  localparam logic [4:0] HUB_WRBYTE = 5'h04;
  localparam logic [4:0] HUB_WRWORD = 5'h05;
  localparam logic [4:0] HUB_WRLONG = 5'h06;

  typedef enum logic [1:0] {
    HST_IDLE   = 2'd0,
    HST_ACCESS = 2'd1,
    HST_RESP   = 2'd2
  } hub_state_e;

endpackage

// File: rtl/acog_hub_lane.sv
// Byte/word/long lane steering for one hub op: write enables, replicated write data
// and right-justified, zero-extended read data. Undefined ops are reported invalid.
module acog_hub_lane
  import acog_hub_resp_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        valid_o,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    valid_o = 1'b0;
    we_o    = 1'b0;
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (op_i)
      HUB_RDBYTE: begin
        valid_o = 1'b1;
        rdata_o = {24'h0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
      end
      HUB_RDWORD: begin
        valid_o = 1'b1;
        rdata_o = {16'h0, rdata_i[{addr_lo_i[1], 4'b0000} +: 16]};
      end
      HUB_RDLONG: begin
        valid_o = 1'b1;
        rdata_o = rdata_i;
      end
      HUB_WRBYTE: begin
        valid_o = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      HUB_WRWORD: begin
        valid_o = 1'b1;
        we_o    = 1'b1;
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      HUB_WRLONG: begin
        valid_o = 1'b1;
        we_o    = 1'b1;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acog_hub_resp.sv
// Hub-side responder: a free-running slot visits each cog in turn and services one held
// request per visit through the single-port hub RAM, returning a one-cycle ack with read data.
//
// state      | meaning
// HST_IDLE   | waiting for req[slot]; accepting edge latches the request and mem_* outputs
// HST_ACCESS | RAM strobe cycle (mem_en_o high for valid ops)
// HST_RESP   | RAM data returning; closing edge registers rdata and the ack pulse
module acog_hub_resp
  import acog_hub_resp_pkg::*;
#(
  parameter int NCOGS = 8,
  parameter int AW    = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic [NCOGS-1:0]      hub_req_in,
  input  logic [5*NCOGS-1:0]    hub_op_in,
  input  logic [AW*NCOGS-1:0]   hub_addr_in,
  input  logic [32*NCOGS-1:0]   hub_wdata_in,
  output logic [NCOGS-1:0]      hub_ack_o,
  output logic [31:0]           hub_rdata_o,
  output logic [2:0]            slot_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [AW-3:0]         mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_in
);

  localparam logic [2:0] SLOT_LAST = 3'(NCOGS - 1);

  hub_state_e       state_q, state_d;
  logic [2:0]       slot_q, slot_d;
  logic [2:0]       cog_q, cog_d;
  logic [4:0]       op_q, op_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [NCOGS-1:0] ack_q, ack_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [AW-3:0]    mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;

  logic             sel_req;
  logic [4:0]       sel_op;
  logic [AW-1:0]    sel_addr;
  logic [31:0]      sel_wdata;

  logic             in_idle;
  logic [4:0]       lane_op;
  logic [1:0]       lane_lo;
  logic             lane_valid;
  logic             lane_we;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_rdata;

  always_comb begin
    sel_req   = 1'b0;
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCOGS; i++) begin
      if (slot_q == 3'(i)) begin
        sel_req   = hub_req_in[i];
        sel_op    = hub_op_in[5*i +: 5];
        sel_addr  = hub_addr_in[AW*i +: AW];
        sel_wdata = hub_wdata_in[32*i +: 32];
      end
    end
  end

  // One lane helper serves both ends: the slot's request while idle, the held op afterwards.
  assign in_idle = (state_q == HST_IDLE);
  assign lane_op = in_idle ? sel_op : op_q;
  assign lane_lo = in_idle ? sel_addr[1:0] : addr_lo_q;

  acog_hub_lane u_lane (
    .op_i      (lane_op),
    .addr_lo_i (lane_lo),
    .wdata_i   (sel_wdata),
    .rdata_i   (mem_rdata_in),
    .valid_o   (lane_valid),
    .we_o      (lane_we),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  assign slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    cog_d       = cog_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    ack_d       = '0;
    rdata_d     = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_q)
      HST_IDLE: begin
        if (sel_req) begin
          state_d   = HST_ACCESS;
          cog_d     = slot_q;
          op_d      = sel_op;
          addr_lo_d = sel_addr[1:0];
          if (lane_valid) begin
            mem_en_d    = 1'b1;
            mem_we_d    = lane_we;
            mem_be_d    = lane_be;
            mem_addr_d  = sel_addr[AW-1:2];
            mem_wdata_d = lane_wdata;
          end
        end
      end
      HST_ACCESS: state_d = HST_RESP;
      HST_RESP: begin
        state_d = HST_IDLE;
        rdata_d = lane_rdata;
        for (int i = 0; i < NCOGS; i++) begin
          ack_d[i] = (cog_q == 3'(i));
        end
      end
      default: state_d = HST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= HST_IDLE;
      slot_q      <= 3'd0;
      cog_q       <= 3'd0;
      op_q        <= '0;
      addr_lo_q   <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cog_q       <= cog_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign hub_ack_o   = ack_q;
  assign hub_rdata_o = rdata_q;
  assign slot_o      = slot_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_acog_hub_resp.sv
// Bench for acog_hub_resp: a transaction-level model (slot = edges mod NCOGS, one service
// every >=3 edges, ack 2 edges after acceptance) checked every cycle, plus directed literals.
module tb_acog_hub_resp;

  localparam int NCOGS = 8;
  localparam int AW    = 16;
  localparam int DEPTH = 1 << (AW - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NCOGS-1:0]    req = '0;
  logic [4:0]          op_a   [NCOGS];
  logic [AW-1:0]       addr_a [NCOGS];
  logic [31:0]         wd_a   [NCOGS];
  logic [5*NCOGS-1:0]  op_bus;
  logic [AW*NCOGS-1:0] addr_bus;
  logic [32*NCOGS-1:0] wd_bus;

  logic [NCOGS-1:0] ack;
  logic [31:0]      rdata;
  logic [2:0]       slot;
  logic             mem_en, mem_we;
  logic [3:0]       mem_be;
  logic [AW-3:0]    mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic [31:0] ram  [DEPTH];
  logic [31:0] gmem [DEPTH];

  int n_pass = 0;
  int n_total = 0;
  int en_hits = 0;

  // model state
  int          cyc = 0;
  bit          acc_any = 1'b0;
  int          acc_edge = 0;
  int          acc_cog = 0;
  logic [4:0]  acc_op;
  logic [15:0] acc_addr;
  logic [31:0] acc_wd;
  logic [31:0] acc_rd;

  logic [4:0] op_tab [7] = '{5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06, 5'h1F};

  always #5 clk = ~clk;

  always_comb begin
    op_bus = '0;
    addr_bus = '0;
    wd_bus = '0;
    for (int i = 0; i < NCOGS; i++) begin
      op_bus[5*i +: 5]     = op_a[i];
      addr_bus[AW*i +: AW] = addr_a[i];
      wd_bus[32*i +: 32]   = wd_a[i];
    end
  end

  acog_hub_resp #(.NCOGS(NCOGS), .AW(AW)) dut (
    .clk_in       (clk),
    .reset_n_in   (rst_n),
    .hub_req_in   (req),
    .hub_op_in    (op_bus),
    .hub_addr_in  (addr_bus),
    .hub_wdata_in (wd_bus),
    .hub_ack_o    (ack),
    .hub_rdata_o  (rdata),
    .slot_o       (slot),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_in (mem_rdata)
  );

  // hub RAM: synchronous, read data the cycle after the strobe
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit op_valid(input logic [4:0] op);
    return op inside {5'h00, 5'h01, 5'h02, 5'h04, 5'h05, 5'h06};
  endfunction

  function automatic bit op_write(input logic [4:0] op);
    return op inside {5'h04, 5'h05, 5'h06};
  endfunction

  task automatic model_accept(input int s);
    logic [31:0] w, mask;
    int idx, bsh, wsh;
    acc_any  = 1'b1;
    acc_edge = cyc + 1;
    acc_cog  = s;
    acc_op   = op_a[s];
    acc_addr = addr_a[s];
    acc_wd   = wd_a[s];
    idx = int'(acc_addr) / 4;
    bsh = 8 * (int'(acc_addr) % 4);
    wsh = 16 * ((int'(acc_addr) / 2) % 2);
    w = gmem[idx];
    acc_rd = '0;
    case (acc_op)
      5'h00: acc_rd = (w >> bsh) & 32'h0000_00FF;
      5'h01: acc_rd = (w >> wsh) & 32'h0000_FFFF;
      5'h02: acc_rd = w;
      5'h04: begin
        mask = 32'hFF << bsh;
        gmem[idx] = (w & ~mask) | ((acc_wd & 32'hFF) << bsh);
      end
      5'h05: begin
        mask = 32'hFFFF << wsh;
        gmem[idx] = (w & ~mask) | ((acc_wd & 32'hFFFF) << wsh);
      end
      5'h06: gmem[idx] = acc_wd;
      default: ;
    endcase
  endtask

  // one clock: model decides the upcoming edge, then outputs are compared after it
  task automatic cycle();
    int s;
    logic [NCOGS-1:0] eack;
    logic [31:0] erd, ebe, ewd;
    bit in_acc, wr;
    s = cyc % NCOGS;
    if (req[s] && (!acc_any || cyc + 1 >= acc_edge + 3)) model_accept(s);
    @(posedge clk);
    #1;
    cyc++;
    if (mem_en) en_hits++;
    eack = '0;
    erd = '0;
    if (acc_any && cyc == acc_edge + 2) begin
      eack[acc_cog] = 1'b1;
      erd = acc_rd;
    end
    in_acc = acc_any && (cyc == acc_edge) && op_valid(acc_op);
    wr = op_write(acc_op);
    chk("ack", 32'(ack), 32'(eack));
    chk("rdata", rdata, erd);
    chk("slot", 32'(slot), 32'(cyc % NCOGS));
    chk("mem_en", 32'(mem_en), 32'(in_acc));
    chk("mem_we", 32'(mem_we), 32'(in_acc && wr));
    if (in_acc) begin
      chk("mem_addr", 32'(mem_addr), 32'(acc_addr >> 2));
      if (wr) begin
        case (acc_op)
          5'h04: begin ebe = 32'(4'b0001 << acc_addr[1:0]); ewd = {4{acc_wd[7:0]}}; end
          5'h05: begin ebe = acc_addr[1] ? 32'hC : 32'h3; ewd = {2{acc_wd[15:0]}}; end
          default: begin ebe = 32'hF; ewd = acc_wd; end
        endcase
        chk("mem_be", 32'(mem_be), ebe);
        chk("mem_wdata", mem_wdata, ewd);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    acc_any = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  task automatic set_req(input int c, input logic [4:0] op, input logic [15:0] a, input logic [31:0] d);
    op_a[c] = op;
    addr_a[c] = a;
    wd_a[c] = d;
    req[c] = 1'b1;
  endtask

  task automatic wait_ack(input int c, input int budget, output int n, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd = '0;
    for (n = 1; n <= budget; n++) begin
      cycle();
      if (ack[c]) begin
        got = 1'b1;
        rd = rdata;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL ack_timeout: cog %0d saw no ack within %0d cycles, want one", c, budget);
    end
    req[c] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n3;
    logic [31:0] rd;
    logic [NCOGS-1:0] busy;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = $urandom;
      gmem[i] = ram[i];
    end
    for (int i = 0; i < NCOGS; i++) begin
      op_a[i] = '0;
      addr_a[i] = '0;
      wd_a[i] = '0;
    end
    do_reset();

    // 1: WRLONG from cog0 at slot 0
    set_req(0, 5'h06, 16'h0100, 32'hDEAD_BEEF);
    cycle();
    req[0] = 1'b0;
    chk("t1_mem_addr", 32'(mem_addr), 32'h0000_0040);
    chk("t1_mem_be", 32'(mem_be), 32'h0000_000F);
    chk("t1_mem_we", 32'(mem_we), 32'h1);
    chk("t1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cycle();
    cycle();
    chk("t1_ack", 32'(ack), 32'h0000_0001);

    // 2: byte and word reads of the long just written
    set_req(2, 5'h00, 16'h0103, 32'h0);
    wait_ack(2, 20, n, rd);
    chk("t2_rdbyte", rd, 32'h0000_00DE);
    set_req(2, 5'h01, 16'h0102, 32'h0);
    wait_ack(2, 20, n, rd);
    chk("t2_rdword", rd, 32'h0000_DEAD);

    // 3: req[5] raised during slot 6 waits for the wrap
    while (cyc % NCOGS != 6) cycle();
    set_req(5, 5'h02, 16'h0100, 32'h0);
    wait_ack(5, 20, n, rd);
    chk("t3_ack_edges", 32'(n), 32'd10);
    chk("t3_rdlong", rd, 32'hDEAD_BEEF);

    // 4: cog1 and cog3 together at slot 0; cog3 skipped while busy, served next rotation
    while (cyc % NCOGS != 0) cycle();
    set_req(1, 5'h02, 16'h0100, 32'h0);
    set_req(3, 5'h01, 16'h0100, 32'h0);
    n1 = 0;
    n3 = 0;
    for (int k = 1; k <= 24; k++) begin
      cycle();
      if (ack[1] && n1 == 0) begin n1 = k; req[1] = 1'b0; end
      if (ack[3] && n3 == 0) begin n3 = k; req[3] = 1'b0; end
    end
    req = '0;
    chk("t4_cog1_edges", 32'(n1), 32'd4);
    chk("t4_cog3_edges", 32'(n3), 32'd14);

    // 5: undefined op
    en_hits = 0;
    set_req(4, 5'h1F, 16'h0100, 32'h1234_5678);
    wait_ack(4, 20, n, rd);
    chk("t5_mem_en_hits", 32'(en_hits), 32'd0);
    chk("t5_rdata", rd, 32'h0);

    // random traffic, including withdrawal after acceptance
    busy = '0;
    for (int k = 0; k < 3000; k++) begin
      cycle();
      if (acc_any && cyc == acc_edge + 2) begin
        req[acc_cog] = 1'b0;
        busy[acc_cog] = 1'b0;
      end
      if (acc_any && cyc == acc_edge && $urandom_range(0, 3) == 0) req[acc_cog] = 1'b0;
      if (k < 2940) begin
        for (int i = 0; i < NCOGS; i++) begin
          if (!busy[i] && $urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 15) == 0) op_a[i] = 5'($urandom_range(7, 31));
            else op_a[i] = op_tab[$urandom_range(0, 5)];
            addr_a[i] = 16'($urandom_range(0, 511));
            wd_a[i] = $urandom;
            req[i] = 1'b1;
            busy[i] = 1'b1;
          end
        end
      end
    end
    req = '0;

    // 6: reset asserted during ACCESS aborts the read with no ack
    while (cyc % NCOGS != 0) cycle();
    set_req(0, 5'h02, 16'h0040, 32'h0);
    cycle();
    chk("t6_en_in_access", 32'(mem_en), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en_abort", 32'(mem_en), 32'h0);
    chk("t6_we_abort", 32'(mem_we), 32'h0);
    chk("t6_ack_abort", 32'(ack), 32'h0);
    do_reset();
    repeat (12) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
